bin_to_bcd_seq: RTL and testbench



---
 rtl/bin_to_bcd_seq_pkg.sv | 36 +++
 rtl/dabble_digit_adj.sv | 27 ++
 rtl/bin_to_bcd_seq.sv | 133 +++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bin_to_bcd_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bin_to_bcd_seq_pkg
//  Purpose  : Shared types, constants and sizing helper for the sequential
//             binary-to-BCD (double dabble) converter.
//  Revision : 1.0 - initial release
// ============================================================================
package bin_to_bcd_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W   = 4;
    localparam int DABBLE_THRESH = 5;
    localparam int DABBLE_ADD    = 3;

    // Smallest digit count d such that 10^d > 2^width.
    function automatic int min_digits(input int width);
        longint unsigned lim;
        longint unsigned pw;
        int              d;
        lim = 64'd1 << width;
        pw  = 64'd1;
        d   = 0;
        while (pw <= lim) begin
            pw = pw * 64'd10;
            d  = d + 1;
        end
        return d;
    endfunction

endpackage : bin_to_bcd_seq_pkg
`default_nettype wire

// File: rtl/dabble_digit_adj.sv
`default_nettype none
// ============================================================================
//  Module   : dabble_digit_adj
//  Purpose  : Combinational double-dabble correction of one BCD digit:
//             values 5..9 get +3, 0..4 pass through, illegal 10..15 go to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module dabble_digit_adj
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit,
    output logic [BCD_DIGIT_W-1:0] adjusted
);

    // Add-3 correction; codes above 9 cannot occur in a healthy scratch
    // register, so they are squashed to zero rather than propagated.
    always_comb begin
        adjusted = digit;
        if (digit > BCD_DIGIT_W'(9)) begin
            adjusted = '0;
        end else if (digit >= BCD_DIGIT_W'(DABBLE_THRESH)) begin
            adjusted = digit + BCD_DIGIT_W'(DABBLE_ADD);
        end
    end

endmodule : dabble_digit_adj
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : bin_to_bcd_seq
//  Purpose  : Sequential binary-to-BCD converter, one shift-and-add-3 step
//             per clock, with optional two's-complement input and a
//             start/busy/done handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          signed_mode,
    input  logic [WIDTH-1:0]              bin_in,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
    output logic                          neg
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH);

    // Parameter sanity: refuse to build a converter that cannot hold the result.
    if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
        $error("bin_to_bcd_seq: WIDTH=%0d outside 4..32", WIDTH);
    end
    if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
        $error("bin_to_bcd_seq: DIGITS=%0d too small for WIDTH=%0d (need %0d)",
               DIGITS, WIDTH, min_digits(WIDTH));
    end

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_mag;
    logic [BCD_W-1:0]   r_scratch;
    logic               r_neg_lat;

    logic               w_load;
    logic               w_last;
    logic               w_neg;
    logic [WIDTH-1:0]   w_mag;
    logic [BCD_W-1:0]   w_adj;
    logic [BCD_W-1:0]   w_scratch_nxt;

    // Start is only honoured when no conversion is in flight.
    assign w_load = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last = (r_state == ST_SHIFT) && (r_cnt == CNT_W'(WIDTH - 1));

    // Negation needs no extra bit: for a negative input the true magnitude
    // is at most 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
    assign w_neg = signed_mode & bin_in[WIDTH-1];
    assign w_mag = w_neg ? (~bin_in + WIDTH'(1)) : bin_in;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        dabble_digit_adj u_adj (
            .digit    (r_scratch[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .adjusted (w_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // Corrected digits shift left, pulling in the magnitude MSB.
    assign w_scratch_nxt = {w_adj[BCD_W-2:0], r_mag[WIDTH-1]};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                w_next_state = start ? ST_SHIFT : ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Operand load, per-cycle dabble iteration and result capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_mag     <= '0;
            r_scratch <= '0;
            r_neg_lat <= 1'b0;
            bcd_out   <= '0;
            neg       <= 1'b0;
        end else if (w_load) begin
            r_cnt     <= '0;
            r_mag     <= w_mag;
            r_scratch <= '0;
            r_neg_lat <= w_neg;
        end else if (r_state == ST_SHIFT) begin
            r_cnt     <= r_cnt + CNT_W'(1);
            r_mag     <= r_mag << 1;
            r_scratch <= w_scratch_nxt;
            if (w_last) begin
                bcd_out <= w_scratch_nxt;
                neg     <= r_neg_lat;
            end
        end
    end

endmodule : bin_to_bcd_seq
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bin_to_bcd_seq
//  Purpose  : Self-checking bench for bin_to_bcd_seq (8-bit/3-digit and
//             16-bit/5-digit instances) against an arithmetic reference.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst_n;

    logic        start;
    logic        signed_mode;
    logic [7:0]  bin_in;
    logic        busy;
    logic        done;
    logic [11:0] bcd_out;
    logic        neg;

    logic        start16;
    logic        signed_mode16;
    logic [15:0] bin_in16;
    logic        busy16;
    logic        done16;
    logic [19:0] bcd_out16;
    logic        neg16;

    int          n_vec = 0;
    int          n_err = 0;
    logic [11:0] last_bcd;
    logic        last_neg;
    logic [19:0] last_bcd16;
    logic        last_neg16;

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .bin_in      (bin_in),
        .busy        (busy),
        .done        (done),
        .bcd_out     (bcd_out),
        .neg         (neg)
    );

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) u_dut16 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start16),
        .signed_mode (signed_mode16),
        .bin_in      (bin_in16),
        .busy        (busy16),
        .done        (done16),
        .bcd_out     (bcd_out16),
        .neg         (neg16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: decimal digits of a magnitude, packed four bits per digit.
    function automatic logic [19:0] ref_bcd(input longint unsigned v, input int nd);
        logic [19:0]     r;
        longint unsigned x;
        r = '0;
        x = v;
        for (int d = 0; d < nd; d++) begin
            r[d*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic longint unsigned ref_mag(input logic sm, input longint unsigned v, input int w);
        if (sm && v[w-1]) return (64'd1 << w) - v;
        return v;
    endfunction

    // One 8-bit conversion. preloaded: start already driven in the previous
    // DONE cycle. poke_at: busy cycle index in which a stray start is driven.
    // chain: drive the next start in this conversion's DONE cycle.
    task automatic convert8(input logic sm, input logic [7:0] v, input bit preloaded,
                            input int poke_at, input logic [7:0] poke_val,
                            input bit chain, input logic [7:0] chain_val);
        logic [11:0] eb;
        logic        en;
        en = sm && v[7];
        eb = 12'(ref_bcd(ref_mag(sm, 64'(v), 8), 3));
        if (!preloaded) begin
            @(negedge clk);
            start = 1'b1; signed_mode = sm; bin_in = v;
        end
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check_eq("busy8", 32'(busy), 1);
            check_eq("done8_early", 32'(done), 0);
            check_eq("bcd8_hold", 32'(bcd_out), 32'(last_bcd));
            check_eq("neg8_hold", 32'(neg), 32'(last_neg));
            if (i == poke_at) begin
                start = 1'b1; signed_mode = ~sm; bin_in = poke_val;
            end else begin
                start = 1'b0; bin_in = 8'($urandom);
            end
        end
        @(negedge clk);
        check_eq("done8", 32'(done), 1);
        check_eq("busy8_end", 32'(busy), 0);
        check_eq("bcd8", 32'(bcd_out), 32'(eb));
        check_eq("neg8", 32'(neg), 32'(en));
        last_bcd = eb;
        last_neg = en;
        if (chain) begin
            start = 1'b1; signed_mode = 1'b0; bin_in = chain_val;
        end else begin
            start = 1'b0;
            @(negedge clk);
            check_eq("done8_pulse", 32'(done), 0);
            check_eq("busy8_idle", 32'(busy), 0);
        end
    endtask

    task automatic convert16(input logic sm, input logic [15:0] v);
        logic [19:0] eb;
        logic        en;
        en = sm && v[15];
        eb = ref_bcd(ref_mag(sm, 64'(v), 16), 5);
        @(negedge clk);
        start16 = 1'b1; signed_mode16 = sm; bin_in16 = v;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            start16 = 1'b0;
            check_eq("busy16", 32'(busy16), 1);
            check_eq("done16_early", 32'(done16), 0);
            check_eq("bcd16_hold", 32'(bcd_out16), 32'(last_bcd16));
        end
        @(negedge clk);
        check_eq("done16", 32'(done16), 1);
        check_eq("bcd16", 32'(bcd_out16), 32'(eb));
        check_eq("neg16", 32'(neg16), 32'(en));
        last_bcd16 = eb;
        last_neg16 = en;
        @(negedge clk);
        check_eq("done16_pulse", 32'(done16), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; signed_mode = 1'b0; bin_in = '0;
        start16 = 1'b0; signed_mode16 = 1'b0; bin_in16 = '0;
        last_bcd = '0; last_neg = 1'b0; last_bcd16 = '0; last_neg16 = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_bcd", 32'(bcd_out), 0);
        check_eq("rst_neg", 32'(neg), 0);
        check_eq("rst_bcd16", 32'(bcd_out16), 0);
        rst_n = 1'b1;

        // Directed corner values.
        convert8(1'b0, 8'hFF, 1'b0, 0, 8'h00, 1'b0, 8'h00);
        convert8(1'b1, 8'h80, 1'b0, 0, 8'h00, 1'b0, 8'h00);
        convert8(1'b1, 8'hF6, 1'b0, 0, 8'h00, 1'b0, 8'h00);
        convert8(1'b1, 8'h00, 1'b0, 0, 8'h00, 1'b0, 8'h00);
        convert8(1'b0, 8'h00, 1'b0, 0, 8'h00, 1'b0, 8'h00);

        // Start while busy must be ignored.
        convert8(1'b0, 8'd99, 1'b0, 4, 8'd7, 1'b0, 8'h00);
        convert8(1'b0, 8'd42, 1'b0, 8, 8'd5, 1'b0, 8'h00);

        // Back-to-back: second start in the DONE cycle.
        convert8(1'b0, 8'd100, 1'b0, 0, 8'h00, 1'b1, 8'd9);
        convert8(1'b0, 8'd9,   1'b1, 0, 8'h00, 1'b0, 8'h00);

        // Reset mid-conversion aborts and clears outputs.
        @(negedge clk);
        start = 1'b1; signed_mode = 1'b0; bin_in = 8'd200;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("abort_busy", 32'(busy), 0);
        check_eq("abort_done", 32'(done), 0);
        check_eq("abort_bcd", 32'(bcd_out), 0);
        check_eq("abort_neg", 32'(neg), 0);
        rst_n = 1'b1;
        last_bcd = '0; last_neg = 1'b0; last_bcd16 = '0; last_neg16 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("abort_no_done", 32'(done), 0);
        end
        convert8(1'b0, 8'd200, 1'b0, 0, 8'h00, 1'b0, 8'h00);

        // Randomized 8-bit conversions, some chained back-to-back.
        begin
            bit          chained;
            logic [7:0]  nxt;
            logic [7:0]  cur;
            logic        cur_sm;
            chained = 1'b0;
            cur     = 8'($urandom);
            cur_sm  = 1'($urandom);
            for (int k = 0; k < 30; k++) begin
                bit do_chain;
                do_chain = ($urandom_range(0, 3) == 0) && (k != 29);
                nxt      = 8'($urandom);
                convert8(cur_sm, cur, chained, $urandom_range(0, 9),
                         8'($urandom), do_chain, nxt);
                chained = do_chain;
                if (do_chain) begin
                    cur    = nxt;
                    cur_sm = 1'b0;
                end else begin
                    cur    = 8'($urandom);
                    cur_sm = 1'($urandom);
                end
            end
        end

        // 16-bit instance.
        convert16(1'b0, 16'hFFFF);
        convert16(1'b1, 16'h8000);
        convert16(1'b1, 16'hFFFF);
        for (int k = 0; k < 8; k++) begin
            convert16(1'($urandom), 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_bin_to_bcd_seq
`default_nettype wire
